pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Drives the instruction memory's fetch address (NPC) and consumes its registered outputs (IR, PC_IF).
//  The memory has exactly one cycle of read latency: at each clk edge it captures mem[npc] into IR and npc into PC_IF.
//  This block owns the program counter. It handles reset boot, sequential advance, zero-bubble branch redirect,
//  decode stall (by replaying the held address) and halt. It presents a qualified instruction to the decode stage.
// PARAMETERS
//  ADDR_W    8    width of the PC and the memory address (the PC_mem_AddrBus width)
//  INSN_W    32   instruction width (the PC_mem_Bus width)
//  RESET_PC  0    first address fetched after reset
//  CNT_W     16   width of the fetched-instruction counter
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst_n      in   1       reset, asynchronous, active-low
//  stall      in   1       decode cannot accept if_ir this cycle
//  br_taken   in   1       redirect request from execute, valid for one cycle
//  br_target  in   ADDR_W  redirect address, sampled when br_taken=1
//  halt_req   in   1       stop fetching after the current word
//  npc        out  ADDR_W  fetch address to instruction memory (combinational)
//  ir_in      in   INSN_W  IR from instruction memory
//  pc_in      in   ADDR_W  PC_IF from instruction memory
//  if_valid   out  1       if_ir/if_pc hold a correct-path instruction
//  if_ir      out  INSN_W  ir_in when if_valid=1, else all zeros (NOP)
//  if_pc      out  ADDR_W  pc_in when if_valid=1, else all zeros
//  halted     out  1       state==HALT
//  fetch_cnt  out  CNT_W   count of instructions accepted by decode (if_valid & ~stall), saturating
// BEHAVIOUR
//  Registers: state, pc_q (next sequential address), f_pc_q (address currently on the memory output), valid_q, fetch_cnt.
//  Reset (async, rst_n=0): state=BOOT, pc_q=RESET_PC, f_pc_q=0, valid_q=0, fetch_cnt=0.
//    Outputs during reset: npc=RESET_PC, if_valid=0, halted=0.
//  npc is combinational. Priority: br_taken -> br_target; else (stall & valid_q) -> f_pc_q (replay); else HALT -> f_pc_q; else pc_q.
//  Replay makes the memory recapture the same word, so ir_in/pc_in are stable across any stall length.
//  States and transitions, evaluated each edge with priority br_taken > halt_req > stall > advance:
//   BOOT : npc=pc_q. At the next edge: f_pc_q<=pc_q, pc_q<=pc_q+1, valid_q<=1, next state RUN. stall has no effect in BOOT.
//   RUN  : if br_taken: f_pc_q<=br_target, pc_q<=br_target+1, valid_q<=1. The next cycle is the target; there is no bubble.
//          The word in decode this cycle is still accepted if ~stall.
//          elif halt_req: valid_q<=0, pc_q and f_pc_q hold, go to HALT.
//          elif stall & valid_q: all registers hold.
//          else: f_pc_q<=pc_q, pc_q<=pc_q+1, valid_q<=1.
//   HALT : if_valid=0 and fetch_cnt frozen.
//          br_taken leaves HALT to RUN, with the same register updates as a branch in RUN. halt_req and stall are ignored.
//  PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 advances to 0 with no flag.
//  fetch_cnt increments when if_valid & ~stall, and holds at 2^CNT_W-1.
//  br_taken together with stall: the branch wins and the stalled word is discarded. The execute stage owns the squash.
//  if_valid and halted come only from registers. Reset asserted mid-operation forces the reset values immediately.
//  Releasing reset re-enters BOOT.
// STRUCTURE
//  Shared package/def include: ADDR_W/INSN_W defaults, the NOP encoding (all zeros), state encodings BOOT=2'd0, RUN=2'd1, HALT=2'd2.
//  The unused encoding 2'd3 recovers to BOOT.
//  Sub-module: pc_sat_counter (CNT_W, enable, saturate) for fetch_cnt. Everything else stays inline.
// TESTING  (bench models the 1-cycle memory with mem[i]=i+0x100)
//  1 Reset release, no stall: npc=0,1,2,3; if_valid rises 1 cycle after release; if_ir=0x100,0x101,0x102; if_pc=0,1,2.
//  2 stall held 3 cycles while if_pc=2: npc=2 throughout, if_ir stays 0x102; after release if_pc=3, fetch_cnt counts 0x102 once.
//  3 br_taken with br_target=0x40 while if_pc=5: the next cycle has if_pc=0x40 and if_ir=0x140, then 0x41, with no bubble.
//  4 ADDR_W=8, run from 0xFE: if_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
//  5 halt_req at if_pc=7: the next cycle has if_valid=0 and halted=1, npc holds; br_taken to 0x10 resumes with if_pc=0x10.
//  6 br_taken and stall together, then rst_n pulsed low mid-run: the branch wins; the reset drives if_valid=0 and npc=RESET_PC asynchronously.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: default widths,
// the NOP encoding and the fetch state encodings.
package pc_fetch_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INSN_W_DEF = 32;

    localparam logic [INSN_W_DEF-1:0] NOP_INSN = '0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating up-counter: increments on en and sticks at all-ones.
module pc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencing for a 1-cycle-latency instruction
// memory: boot, sequential advance, zero-bubble redirect, stall replay, halt.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSN_W   = INSN_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] npc,
    input  logic [INSN_W-1:0] ir_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              if_valid,
    output logic [INSN_W-1:0] if_ir,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] f_pc_q;
    logic              valid_q;

    // Replaying f_pc_q makes the memory recapture the held word during a stall.
    always_comb begin
        if (br_taken) begin
            npc = br_target;
        end else if (stall && valid_q) begin
            npc = f_pc_q;
        end else if (state == ST_HALT) begin
            npc = f_pc_q;
        end else begin
            npc = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_PC;
            f_pc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    // A redirect during boot is honoured so npc and f_pc_q stay in step.
                    if (br_taken) begin
                        f_pc_q <= br_target;
                        pc_q   <= br_target + PC_ONE;
                    end else begin
                        f_pc_q <= pc_q;
                        pc_q   <= pc_q + PC_ONE;
                    end
                    valid_q <= 1'b1;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (br_taken) begin
                        f_pc_q  <= br_target;
                        pc_q    <= br_target + PC_ONE;
                        valid_q <= 1'b1;
                    end else if (halt_req) begin
                        valid_q <= 1'b0;
                        state   <= ST_HALT;
                    end else if (!(stall && valid_q)) begin
                        f_pc_q  <= pc_q;
                        pc_q    <= pc_q + PC_ONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (br_taken) begin
                        f_pc_q  <= br_target;
                        pc_q    <= br_target + PC_ONE;
                        valid_q <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= ST_BOOT;
                end
            endcase
        end
    end

    assign if_valid = valid_q;
    assign halted   = (state == ST_HALT);
    assign if_ir    = valid_q ? ir_in : INSN_W'(NOP_INSN);
    assign if_pc    = valid_q ? pc_in : '0;

    pc_sat_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (valid_q && !stall),
        .cnt   (fetch_cnt)
    );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a 1-cycle memory model (mem[i]=i+0x100).
module tb_pc_fetch_ctrl;

    localparam int ADDR_W = 8;
    localparam int INSN_W = 32;
    localparam int CNT_W  = 16;
    localparam int NVEC   = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, br_taken, halt_req;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] npc, pc_in, if_pc;
    logic [INSN_W-1:0] ir_in, if_ir;
    logic              if_valid, halted;
    logic [CNT_W-1:0]  fetch_cnt;

    // Small-counter instance used only to reach saturation quickly.
    logic [ADDR_W-1:0] npc2, pc_in2, if_pc2;
    logic [INSN_W-1:0] ir_in2, if_ir2;
    logic              if_valid2, halted2;
    logic [2:0]        fetch_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        ir_in  <= 32'h100 + 32'(npc);
        pc_in  <= npc;
        ir_in2 <= 32'h100 + 32'(npc2);
        pc_in2 <= npc2;
    end

    pc_fetch_ctrl #(
        .ADDR_W(ADDR_W), .INSN_W(INSN_W), .RESET_PC(8'h00), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .halt_req(halt_req), .npc(npc),
        .ir_in(ir_in), .pc_in(pc_in), .if_valid(if_valid), .if_ir(if_ir),
        .if_pc(if_pc), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    pc_fetch_ctrl #(
        .ADDR_W(ADDR_W), .INSN_W(INSN_W), .RESET_PC(8'h00), .CNT_W(3)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .br_taken(1'b0),
        .br_target(8'h00), .halt_req(1'b0), .npc(npc2),
        .ir_in(ir_in2), .pc_in(pc_in2), .if_valid(if_valid2), .if_ir(if_ir2),
        .if_pc(if_pc2), .halted(halted2), .fetch_cnt(fetch_cnt2)
    );

    typedef struct {
        logic              stall;
        logic              br;
        logic [ADDR_W-1:0] tgt;
        logic              halt;
        logic [ADDR_W-1:0] e_npc;
        logic              e_vld;
        logic [INSN_W-1:0] e_ir;
        logic [ADDR_W-1:0] e_pc;
        logic              e_hlt;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall br tgt halt | npc vld ir pc halted cnt
        vecs[0]  = '{0, 0, 8'h00, 0, 8'h00, 0, 32'h000, 8'h00, 0, 16'd0};
        vecs[1]  = '{0, 0, 8'h00, 0, 8'h01, 1, 32'h100, 8'h00, 0, 16'd0};
        vecs[2]  = '{0, 0, 8'h00, 0, 8'h02, 1, 32'h101, 8'h01, 0, 16'd1};
        vecs[3]  = '{1, 0, 8'h00, 0, 8'h02, 1, 32'h102, 8'h02, 0, 16'd2};
        vecs[4]  = '{1, 0, 8'h00, 0, 8'h02, 1, 32'h102, 8'h02, 0, 16'd2};
        vecs[5]  = '{1, 0, 8'h00, 0, 8'h02, 1, 32'h102, 8'h02, 0, 16'd2};
        vecs[6]  = '{0, 0, 8'h00, 0, 8'h03, 1, 32'h102, 8'h02, 0, 16'd2};
        vecs[7]  = '{0, 0, 8'h00, 0, 8'h04, 1, 32'h103, 8'h03, 0, 16'd3};
        vecs[8]  = '{0, 0, 8'h00, 0, 8'h05, 1, 32'h104, 8'h04, 0, 16'd4};
        vecs[9]  = '{0, 1, 8'h40, 0, 8'h40, 1, 32'h105, 8'h05, 0, 16'd5};
        vecs[10] = '{0, 0, 8'h00, 0, 8'h41, 1, 32'h140, 8'h40, 0, 16'd6};
        vecs[11] = '{0, 1, 8'hFE, 0, 8'hFE, 1, 32'h141, 8'h41, 0, 16'd7};
        vecs[12] = '{0, 0, 8'h00, 0, 8'hFF, 1, 32'h1FE, 8'hFE, 0, 16'd8};
        vecs[13] = '{0, 0, 8'h00, 0, 8'h00, 1, 32'h1FF, 8'hFF, 0, 16'd9};
        vecs[14] = '{0, 0, 8'h00, 0, 8'h01, 1, 32'h100, 8'h00, 0, 16'd10};
        vecs[15] = '{0, 1, 8'h07, 0, 8'h07, 1, 32'h101, 8'h01, 0, 16'd11};
        vecs[16] = '{0, 0, 8'h00, 1, 8'h08, 1, 32'h107, 8'h07, 0, 16'd12};
        vecs[17] = '{0, 0, 8'h00, 0, 8'h07, 0, 32'h000, 8'h00, 1, 16'd13};
        vecs[18] = '{1, 0, 8'h00, 1, 8'h07, 0, 32'h000, 8'h00, 1, 16'd13};
        vecs[19] = '{0, 1, 8'h10, 0, 8'h10, 0, 32'h000, 8'h00, 1, 16'd13};
        vecs[20] = '{0, 0, 8'h00, 0, 8'h11, 1, 32'h110, 8'h10, 0, 16'd13};
        vecs[21] = '{1, 1, 8'h20, 0, 8'h20, 1, 32'h111, 8'h11, 0, 16'd14};
        vecs[22] = '{0, 0, 8'h00, 0, 8'h21, 1, 32'h120, 8'h20, 0, 16'd14};
        vecs[23] = '{0, 0, 8'h00, 0, 8'h22, 1, 32'h121, 8'h21, 0, 16'd15};

        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0; halt_req = 1'b0;
        repeat (2) step();
        chk("rst_npc",      32'(npc),       32'h0);
        chk("rst_if_valid", 32'(if_valid),  32'h0);
        chk("rst_halted",   32'(halted),    32'h0);
        chk("rst_fetch_cnt",32'(fetch_cnt), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            stall = vecs[i].stall; br_taken = vecs[i].br;
            br_target = vecs[i].tgt; halt_req = vecs[i].halt;
            #1;
            chk($sformatf("v%0d_npc", i),       32'(npc),       32'(vecs[i].e_npc));
            chk($sformatf("v%0d_if_valid", i),  32'(if_valid),  32'(vecs[i].e_vld));
            chk($sformatf("v%0d_if_ir", i),     if_ir,          vecs[i].e_ir);
            chk($sformatf("v%0d_if_pc", i),     32'(if_pc),     32'(vecs[i].e_pc));
            chk($sformatf("v%0d_halted", i),    32'(halted),    32'(vecs[i].e_hlt));
            chk($sformatf("v%0d_fetch_cnt", i), 32'(fetch_cnt), 32'(vecs[i].e_cnt));
            step();
        end
        stall = 1'b0; br_taken = 1'b0; br_target = '0; halt_req = 1'b0;

        // Asynchronous reset mid-cycle, well away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_npc",       32'(npc),       32'h0);
        chk("async_if_valid",  32'(if_valid),  32'h0);
        chk("async_if_ir",     if_ir,          32'h0);
        chk("async_halted",    32'(halted),    32'h0);
        chk("async_fetch_cnt", 32'(fetch_cnt), 32'h0);

        step();
        rst_n = 1'b1;
        #1;
        chk("reboot_npc",      32'(npc),      32'h0);
        chk("reboot_if_valid", 32'(if_valid), 32'h0);
        step(); #1;
        chk("reboot1_if_valid", 32'(if_valid), 32'h1);
        chk("reboot1_if_pc",    32'(if_pc),    32'h0);
        chk("reboot1_if_ir",    if_ir,         32'h100);
        chk("reboot1_npc",      32'(npc),      32'h1);

        repeat (4) step();
        chk("c5_fetch_cnt",  32'(fetch_cnt),  32'd4);
        chk("c5_sat_cnt",    32'(fetch_cnt2), 32'd4);
        repeat (7) step();
        chk("c12_fetch_cnt", 32'(fetch_cnt),  32'd11);
        chk("c12_sat_cnt",   32'(fetch_cnt2), 32'd7);
        chk("c12_sat_if_pc", 32'(if_pc2),     32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
